uart_rx_core: RTL and testbench

Parametrised UART receive engine, successor to the fixed 8N1 receiver that drives the seven-segment debug display. It synchronises the raw RXD pin and validates the start bit at mid-bit. It deserialises 5–9 data bits LSB-first, with optional parity and one or two stop bits. Each received word is presented on a ready/valid output holding register, along with framing-error, parity-error, break and overrun status.

---
 rtl/uart_rx_core.sv | 117 +++++++++++
 tb/tb_uart_rx_core.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: parametrised UART receiver (5-9 data bits, optional parity, 1-2 stop bits)
// with a ready/valid holding register and framing, parity, break and overrun status.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] H    = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP1, STOP2, COMMIT, BRK} state_t;
    state_t state, state_n;
    logic [1:0] sync;
    logic rx_s, tick, brk, pe_calc, load;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic par_bit, par_bit_n, fe_int, fe_int_n, stop_hi, stop_hi_n;
    assign rx_s = sync[1];
    assign busy = state != IDLE;
    assign tick = cnt == LAST;
    // A break needs every sampled bit low, stops included; stop_hi records any high stop bit.
    assign brk = ~|shift && (PARITY == 0 || !par_bit) && !stop_hi;
    assign pe_calc = PARITY == 1 ? ~(^shift ^ par_bit) : PARITY == 2 ? (^shift ^ par_bit) : 1'b0;
    assign load = state == COMMIT && !brk && (!data_valid || data_ready);
    assign cnt_n = (state_n != state || tick) ? '0 : cnt + 1'b1;
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        shift_n   = shift;
        par_bit_n = par_bit;
        fe_int_n  = fe_int;
        stop_hi_n = stop_hi;
        case (state)
            IDLE: begin
                idx_n     = '0;
                par_bit_n = 1'b0;
                fe_int_n  = 1'b0;
                stop_hi_n = 1'b0;
                if (!rx_s) state_n = START;
            end
            START: if (cnt == H) state_n = rx_s ? IDLE : DATA;
            DATA: if (tick) begin
                shift_n[idx] = rx_s;
                idx_n = idx + 1'b1;
                if (idx == IDX_LAST) state_n = PARITY != 0 ? PAR : STOP1;
            end
            PAR: if (tick) begin
                par_bit_n = rx_s;
                state_n = STOP1;
            end
            STOP1: if (tick) begin
                fe_int_n  = fe_int | ~rx_s;
                stop_hi_n = stop_hi | rx_s;
                state_n   = STOP_BITS == 2 ? STOP2 : COMMIT;
            end
            STOP2: if (tick) begin
                fe_int_n  = fe_int | ~rx_s;
                stop_hi_n = stop_hi | rx_s;
                state_n   = COMMIT;
            end
            COMMIT: state_n = brk ? BRK : IDLE;
            BRK: if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync       <= 2'b11;
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            fe_int     <= 1'b0;
            stop_hi    <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sync       <= {sync[0], uart_rxd};
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            shift      <= shift_n;
            par_bit    <= par_bit_n;
            fe_int     <= fe_int_n;
            stop_hi    <= stop_hi_n;
            if (load) begin
                data       <= shift;
                frame_err  <= fe_int;
                parity_err <= pe_calc;
            end
            data_valid <= load | (data_valid & ~data_ready);
            break_det  <= state == COMMIT && brk;
            overrun    <= state == COMMIT && !brk && data_valid && !data_ready;
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scoreboard bench driving 8N1, 7E1 and 8N2 receivers at 16 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx_core;
    localparam int CPB = 16;
    localparam int H = (CPB - 1) / 2;
    typedef struct {logic [8:0] d; logic fe; logic pe;} exp_t;
    typedef struct {int u; logic [8:0] d; logic pflip; logic s2low; logic [8:0] ed; logic efe; logic epe;} vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd [3];
    logic rdy [3];
    logic dv [3], fe [3], pe [3], bd [3], ov [3], bz [3];
    logic [7:0] d0, d2;
    logic [6:0] d1;
    logic [8:0] dat [3];
    int cyc = 0, ncmp = 0, nerr = 0;
    vec_t vt [7];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign dat[0] = {1'b0, d0};
    assign dat[1] = {2'b0, d1};
    assign dat[2] = {1'b0, d2};
    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .uart_rxd(rxd[0]), .data(d0), .data_valid(dv[0]), .data_ready(rdy[0]),
        .frame_err(fe[0]), .parity_err(pe[0]), .break_det(bd[0]), .overrun(ov[0]), .busy(bz[0]));
    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .uart_rxd(rxd[1]), .data(d1), .data_valid(dv[1]), .data_ready(rdy[1]),
        .frame_err(fe[1]), .parity_err(pe[1]), .break_det(bd[1]), .overrun(ov[1]), .busy(bz[1]));
    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .uart_rxd(rxd[2]), .data(d2), .data_valid(dv[2]), .data_ready(rdy[2]),
        .frame_err(fe[2]), .parity_err(pe[2]), .break_det(bd[2]), .overrun(ov[2]), .busy(bz[2]));
    task automatic chk(input string n, input int a, input int e);
        ncmp++;
        if (a != e) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", n, a, e);
        end
    endtask
    for (genvar g = 0; g < 3; g++) begin : mon
        exp_t q[$];
        exp_t e;
        int nvalid = 0, nbrk = 0, novr = 0, nbusy = 0, rise = -1;
        logic dvq = 1'b0;
        initial forever begin
            @(negedge clk);
            nvalid += int'(dv[g] === 1'b1);
            nbrk   += int'(bd[g] === 1'b1);
            novr   += int'(ov[g] === 1'b1);
            nbusy  += int'(bz[g] === 1'b1);
            if (dv[g] === 1'b1 && dvq !== 1'b1) rise = cyc;
            dvq = dv[g];
            if (dv[g] === 1'b1 && rdy[g]) begin
                chk($sformatf("u%0d word pending", g), int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk($sformatf("u%0d data", g), int'(dat[g]), int'(e.d));
                    chk($sformatf("u%0d frame_err", g), int'(fe[g]), int'(e.fe));
                    chk($sformatf("u%0d parity_err", g), int'(pe[g]), int'(e.pe));
                end
            end
        end
    end
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic push(input int u, input logic [8:0] d, input logic f, input logic p);
        exp_t e;
        e.d = d;
        e.fe = f;
        e.pe = p;
        case (u)
            0: mon[0].q.push_back(e);
            1: mon[1].q.push_back(e);
            default: mon[2].q.push_back(e);
        endcase
    endtask
    // u selects the framing: 0 = 8N1, 1 = 7E1, 2 = 8N2; nline > 0 drives only that many line bits
    task automatic send(input int u, input logic [8:0] d, input logic pflip, input logic s2low, input int nline);
        logic lb [13];
        int nb, len;
        logic p;
        nb = u == 1 ? 7 : 8;
        p = pflip;
        lb[0] = 1'b0;
        for (int i = 0; i < nb; i++) begin
            lb[i+1] = d[i];
            p ^= d[i];
        end
        len = nb + 1;
        if (u == 1) begin
            lb[len] = p;
            len++;
        end
        lb[len] = 1'b1;
        len++;
        if (u == 2) begin
            lb[len] = ~s2low;
            len++;
        end
        if (nline > 0) len = nline;
        for (int i = 0; i < len; i++) begin
            rxd[u] = lb[i];
            idle(CPB);
        end
        if (nline == 0) rxd[u] = 1'b1;
    endtask
    initial begin
        int c, s0, s1, s2;
        for (int i = 0; i < 3; i++) begin
            rxd[i] = 1'b1;
            rdy[i] = 1'b1;
        end
        vt[0] = '{1, 9'h41, 1'b0, 1'b0, 9'h41, 1'b0, 1'b0};
        vt[1] = '{1, 9'h41, 1'b1, 1'b0, 9'h41, 1'b0, 1'b1};
        vt[2] = '{2, 9'hC3, 1'b0, 1'b1, 9'hC3, 1'b1, 1'b0};
        vt[3] = '{0, 9'h00, 1'b0, 1'b0, 9'h00, 1'b0, 1'b0};
        vt[4] = '{0, 9'hFF, 1'b0, 1'b0, 9'hFF, 1'b0, 1'b0};
        vt[5] = '{1, 9'h7F, 1'b0, 1'b0, 9'h7F, 1'b0, 1'b0};
        vt[6] = '{2, 9'h3C, 1'b0, 1'b0, 9'h3C, 1'b0, 1'b0};
        idle(3);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("u%0d reset data", g), int'(dat[g]), 0);
            chk($sformatf("u%0d reset data_valid", g), int'(dv[g]), 0);
            chk($sformatf("u%0d reset frame_err", g), int'(fe[g]), 0);
            chk($sformatf("u%0d reset parity_err", g), int'(pe[g]), 0);
            chk($sformatf("u%0d reset break_det", g), int'(bd[g]), 0);
            chk($sformatf("u%0d reset overrun", g), int'(ov[g]), 0);
            chk($sformatf("u%0d reset busy", g), int'(bz[g]), 0);
        end
        rst = 1'b0;
        idle(10);
        // 8N1 latency: START 3 cycles after the pin edge, last stop sampled 9 bits after mid-start, 2 more to data_valid
        c = cyc;
        s0 = mon[0].nvalid;
        push(0, 9'hA5, 1'b0, 1'b0);
        send(0, 9'hA5, 1'b0, 1'b0, 0);
        idle(10);
        chk("8N1 data_valid cycle", mon[0].rise - c, 3 + H + 9 * CPB + 2);
        chk("8N1 data_valid width", mon[0].nvalid - s0, 1);
        for (int i = 0; i < 7; i++) begin
            push(vt[i].u, vt[i].ed, vt[i].efe, vt[i].epe);
            send(vt[i].u, vt[i].d, vt[i].pflip, vt[i].s2low, 0);
            idle(5);
        end
        // glitch shorter than half a bit: START lasts H+1 cycles, then back to IDLE silently
        s0 = mon[0].nbusy;
        s1 = mon[0].nvalid;
        s2 = mon[0].nbrk;
        rxd[0] = 1'b0;
        idle(5);
        rxd[0] = 1'b1;
        idle(30);
        chk("glitch busy cycles", mon[0].nbusy - s0, H + 1);
        chk("glitch busy idle", int'(bz[0]), 0);
        chk("glitch no data", mon[0].nvalid - s1, 0);
        chk("glitch no break", mon[0].nbrk - s2, 0);
        // two frame times of low line on 8N2
        s0 = mon[2].nbrk;
        s1 = mon[2].nvalid;
        s2 = mon[2].novr;
        rxd[2] = 1'b0;
        idle(2 * 11 * CPB);
        chk("break busy held", int'(bz[2]), 1);
        rxd[2] = 1'b1;
        idle(10);
        chk("break pulse count", mon[2].nbrk - s0, 1);
        chk("break no data", mon[2].nvalid - s1, 0);
        chk("break no overrun", mon[2].novr - s2, 0);
        chk("break back to idle", int'(bz[2]), 0);
        push(2, 9'h96, 1'b0, 1'b0);
        send(2, 9'h96, 1'b0, 1'b0, 0);
        idle(10);
        // back-pressure on 8N1
        rdy[0] = 1'b0;
        s0 = mon[0].novr;
        push(0, 9'h11, 1'b0, 1'b0);
        send(0, 9'h11, 1'b0, 1'b0, 0);
        idle(3);
        send(0, 9'h22, 1'b0, 1'b0, 0);
        idle(3);
        chk("overrun pulse", mon[0].novr - s0, 1);
        chk("overrun valid held", int'(dv[0]), 1);
        chk("overrun data kept", int'(dat[0]), 'h11);
        push(0, 9'h33, 1'b0, 1'b0);
        c = cyc;
        fork
            send(0, 9'h33, 1'b0, 1'b0, 0);
            begin
                idle(4 + H + 9 * CPB);
                rdy[0] = 1'b1;
            end
        join
        idle(5);
        chk("drain on commit no overrun", mon[0].novr - s0, 1);
        chk("drain on commit data", int'(dat[0]), 'h33);
        // reset in the middle of data bit 3
        send(0, 9'h77, 1'b0, 1'b0, 4);
        rxd[0] = 1'b0;
        idle(6);
        chk("mid-frame busy", int'(bz[0]), 1);
        rst = 1'b1;
        idle(1);
        chk("mid-rst data", int'(dat[0]), 0);
        chk("mid-rst data_valid", int'(dv[0]), 0);
        chk("mid-rst frame_err", int'(fe[0]), 0);
        chk("mid-rst parity_err", int'(pe[0]), 0);
        chk("mid-rst break_det", int'(bd[0]), 0);
        chk("mid-rst overrun", int'(ov[0]), 0);
        chk("mid-rst busy", int'(bz[0]), 0);
        rxd[0] = 1'b1;
        idle(2);
        rst = 1'b0;
        s0 = mon[0].nbrk;
        s1 = mon[0].novr;
        s2 = mon[0].nvalid;
        idle(20);
        chk("post-rst no break", mon[0].nbrk - s0, 0);
        chk("post-rst no overrun", mon[0].novr - s1, 0);
        chk("post-rst no data", mon[0].nvalid - s2, 0);
        chk("post-rst idle", int'(bz[0]), 0);
        push(0, 9'h5A, 1'b0, 1'b0);
        send(0, 9'h5A, 1'b0, 1'b0, 0);
        idle(20);
        chk("u0 queue drained", mon[0].q.size(), 0);
        chk("u1 queue drained", mon[1].q.size(), 0);
        chk("u2 queue drained", mon[2].q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
